// File: rtl/control_pipe_unit.sv
`default_nettype none
// ============================================================================
// Module      : control_pipe_unit
// Description : ID-stage main decoder with ID/EX control register, load-use
//               hazard stall FSM, taken-branch flush and a bubble counter.
// Revision    : 1.0 - initial release
// ============================================================================
module control_pipe_unit #(
    parameter int REG_AW          = 5,
    parameter int LOAD_USE_STALLS = 1,
    parameter int ENABLE_JUMP     = 0,
    parameter int CNT_W           = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    input  logic [6:0]        opcode,
    input  logic [REG_AW-1:0] rs1,
    input  logic [REG_AW-1:0] rs2,
    input  logic [REG_AW-1:0] rd,
    input  logic              branch_taken,
    output logic              ex_ALUSrc,
    output logic              ex_MemtoReg,
    output logic              ex_RegWrite,
    output logic              ex_MemRead,
    output logic              ex_MemWrite,
    output logic              ex_Branch,
    output logic              ex_Jump,
    output logic [1:0]        ex_ALUop,
    output logic [REG_AW-1:0] ex_rd,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              if_id_flush,
    output logic              illegal_op,
    output logic [CNT_W-1:0]  bubble_cnt
);

    localparam logic [6:0] c_OP_NOP    = 7'b0000000;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] c_OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;

    localparam logic [0:0] c_ST_RUN   = 1'b0;
    localparam logic [0:0] c_ST_STALL = 1'b1;

    // Stall cycles still owed after the bubble issued in the hazard cycle
    localparam logic [1:0] c_STALL_INIT = 2'(LOAD_USE_STALLS - 1);

    logic [0:0] r_state;
    logic [0:0] w_state_nxt;
    logic [1:0] r_stall_left;
    logic [1:0] w_stall_left_nxt;

    // Control word order: {ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUop[1:0]}
    logic [7:0] w_dec_ctrl;
    logic       w_dec_jump;
    logic       w_dec_legal;
    logic       w_rs1_used;
    logic       w_rs2_used;
    logic       w_hazard;
    logic       w_bubble;

    // Main decoder, also reports which source registers the instruction reads
    always_comb begin
        w_dec_ctrl  = 8'b0000_0000;
        w_dec_jump  = 1'b0;
        w_dec_legal = 1'b0;
        w_rs1_used  = 1'b0;
        w_rs2_used  = 1'b0;
        case (opcode)
            c_OP_NOP:    w_dec_legal = 1'b1;
            c_OP_LOAD:   begin w_dec_ctrl = 8'b1111_0000; w_dec_legal = 1'b1; w_rs1_used = 1'b1; end
            c_OP_STORE:  begin w_dec_ctrl = 8'b1000_1000; w_dec_legal = 1'b1; w_rs1_used = 1'b1; w_rs2_used = 1'b1; end
            c_OP_RTYPE:  begin w_dec_ctrl = 8'b0010_0010; w_dec_legal = 1'b1; w_rs1_used = 1'b1; w_rs2_used = 1'b1; end
            c_OP_ITYPE:  begin w_dec_ctrl = 8'b1010_0011; w_dec_legal = 1'b1; w_rs1_used = 1'b1; end
            c_OP_BRANCH: begin w_dec_ctrl = 8'b0000_0101; w_dec_legal = 1'b1; w_rs1_used = 1'b1; w_rs2_used = 1'b1; end
            c_OP_JAL: begin
                if (ENABLE_JUMP != 0) begin
                    w_dec_ctrl  = 8'b0010_0000;
                    w_dec_jump  = 1'b1;
                    w_dec_legal = 1'b1;
                end
            end
            c_OP_JALR: begin
                if (ENABLE_JUMP != 0) begin
                    w_dec_ctrl  = 8'b1010_0000;
                    w_dec_jump  = 1'b1;
                    w_dec_legal = 1'b1;
                    w_rs1_used  = 1'b1;
                end
            end
            c_OP_LUI: begin
                if (ENABLE_JUMP != 0) begin
                    w_dec_ctrl  = 8'b1010_0000;
                    w_dec_legal = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Load-use hazard against the load currently sitting in ID/EX
    assign w_hazard = instr_valid & ex_MemRead & (ex_rd != '0) &
                      ((w_rs1_used & (rs1 == ex_rd)) | (w_rs2_used & (rs2 == ex_rd)));

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_ST_RUN;
            r_stall_left <= 2'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_stall_left <= w_stall_left_nxt;
        end
    end

    // FSM next state: a taken branch aborts any stall in progress
    always_comb begin
        w_state_nxt      = r_state;
        w_stall_left_nxt = r_stall_left;
        if (branch_taken) begin
            w_state_nxt      = c_ST_RUN;
            w_stall_left_nxt = 2'd0;
        end else begin
            case (r_state)
                c_ST_RUN: begin
                    if (w_hazard && (LOAD_USE_STALLS > 1)) begin
                        w_state_nxt      = c_ST_STALL;
                        w_stall_left_nxt = c_STALL_INIT;
                    end
                end
                c_ST_STALL: begin
                    w_stall_left_nxt = r_stall_left - 2'd1;
                    if (r_stall_left <= 2'd1) begin
                        w_state_nxt = c_ST_RUN;
                    end
                end
                default: begin
                    w_state_nxt      = c_ST_RUN;
                    w_stall_left_nxt = 2'd0;
                end
            endcase
        end
    end

    // FSM outputs: pipeline enables, flush and bubble request
    always_comb begin
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        if_id_flush = 1'b0;
        w_bubble    = 1'b0;
        if (reset) begin
            w_bubble = 1'b0;
        end else if (branch_taken) begin
            if_id_flush = 1'b1;
            w_bubble    = 1'b1;
        end else if ((r_state == c_ST_STALL) || w_hazard) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            w_bubble    = 1'b1;
        end
    end

    // ID/EX register: bubble, decoded controls, or zeros for invalid/illegal slots
    always_ff @(posedge clk) begin
        if (reset || w_bubble) begin
            {ex_ALUSrc, ex_MemtoReg, ex_RegWrite, ex_MemRead,
             ex_MemWrite, ex_Branch, ex_ALUop} <= 8'b0000_0000;
            ex_Jump    <= 1'b0;
            ex_rd      <= '0;
            illegal_op <= 1'b0;
        end else if (instr_valid && w_dec_legal) begin
            {ex_ALUSrc, ex_MemtoReg, ex_RegWrite, ex_MemRead,
             ex_MemWrite, ex_Branch, ex_ALUop} <= w_dec_ctrl;
            ex_Jump    <= w_dec_jump;
            ex_rd      <= rd;
            illegal_op <= 1'b0;
        end else begin
            {ex_ALUSrc, ex_MemtoReg, ex_RegWrite, ex_MemRead,
             ex_MemWrite, ex_Branch, ex_ALUop} <= 8'b0000_0000;
            ex_Jump    <= 1'b0;
            ex_rd      <= '0;
            illegal_op <= instr_valid;
        end
    end

    // Saturating count of inserted bubbles
    always_ff @(posedge clk) begin
        if (reset) begin
            bubble_cnt <= '0;
        end else if (w_bubble && (bubble_cnt != {CNT_W{1'b1}})) begin
            bubble_cnt <= bubble_cnt + CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_control_pipe_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_control_pipe_unit
// Description : Three parameter variants driven by shared stimulus, each
//               compared every cycle against a behavioural model, plus
//               directed literal checks of the documented scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_control_pipe_unit;

    localparam int NI = 3;

    localparam logic [6:0] OP_NOP  = 7'b0000000;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    // Variant 0: defaults; 1: three stalls + jumps; 2: single stall, jumps, 2-bit counter
    function automatic int lus_of(input int i);
        return (i == 1) ? 3 : 1;
    endfunction
    function automatic int ej_of(input int i);
        return (i == 0) ? 0 : 1;
    endfunction
    function automatic int cw_of(input int i);
        return (i == 2) ? 2 : 16;
    endfunction

    logic       clk = 1'b1;
    logic       reset;
    logic       instr_valid;
    logic [6:0] opcode;
    logic [4:0] rs1, rs2, rd;
    logic       branch_taken;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // obs layout: [7:0] ctrl, [8] jump, [13:9] rd, [14] illegal, [15] pc_write,
    //             [16] if_id_write, [17] if_id_flush, [47:32] bubble_cnt
    wire [47:0] obs [NI];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        localparam int CW = cw_of(gi);
        wire          alusrc, memtoreg, regwrite, memread, memwrite, branch, jump;
        wire [1:0]    aluop;
        wire [4:0]    exrd;
        wire          pcw, ifw, flush, ill;
        wire [CW-1:0] cnt;

        control_pipe_unit #(
            .REG_AW(5), .LOAD_USE_STALLS(lus_of(gi)),
            .ENABLE_JUMP(ej_of(gi)), .CNT_W(CW)
        ) u_dut (
            .clk(clk), .reset(reset), .instr_valid(instr_valid), .opcode(opcode),
            .rs1(rs1), .rs2(rs2), .rd(rd), .branch_taken(branch_taken),
            .ex_ALUSrc(alusrc), .ex_MemtoReg(memtoreg), .ex_RegWrite(regwrite),
            .ex_MemRead(memread), .ex_MemWrite(memwrite), .ex_Branch(branch),
            .ex_Jump(jump), .ex_ALUop(aluop), .ex_rd(exrd),
            .pc_write(pcw), .if_id_write(ifw), .if_id_flush(flush),
            .illegal_op(ill), .bubble_cnt(cnt)
        );

        assign obs[gi] = {16'(cnt), 14'd0, flush, ifw, pcw, ill, exrd, jump,
                          alusrc, memtoreg, regwrite, memread, memwrite, branch, aluop};
    end

    // ---------------- behavioural model ----------------
    // Returns {legal, rs2_used, rs1_used, jump, ctrl[7:0]} straight from the opcode table
    function automatic logic [11:0] spec_decode(input logic [6:0] op, input int ej);
        logic [11:0] r;
        r = 12'h000;
        if (op == OP_NOP)  r = {4'b1000, 8'b0000_0000};
        if (op == OP_LW)   r = {4'b1010, 8'b1111_0000};
        if (op == OP_SW)   r = {4'b1110, 8'b1000_1000};
        if (op == OP_R)    r = {4'b1110, 8'b0010_0010};
        if (op == OP_I)    r = {4'b1010, 8'b1010_0011};
        if (op == OP_BR)   r = {4'b1110, 8'b0000_0101};
        if (ej != 0) begin
            if (op == OP_JAL)  r = {4'b1001, 8'b0010_0000};
            if (op == OP_JALR) r = {4'b1011, 8'b1010_0000};
            if (op == OP_LUI)  r = {4'b1000, 8'b1010_0000};
        end
        return r;
    endfunction

    logic [7:0] m_ctrl [NI], n_ctrl [NI];
    logic       m_jump [NI], n_jump [NI];
    logic [4:0] m_rd   [NI], n_rd   [NI];
    logic       m_rdchk[NI], n_rdchk[NI];
    logic       m_ill  [NI], n_ill  [NI];
    int         m_cnt  [NI], n_cnt  [NI];
    int         m_pend [NI], n_pend [NI];   // forced bubbles still owed
    logic       m_ok = 1'b0;

    // Compare process: checks every variant each cycle, then computes the model's next state
    initial forever begin
        @(negedge clk);
        cyc++;
        for (int i = 0; i < NI; i++) begin
            logic [11:0] dec;
            logic        haz, e_pc, e_ifw, e_fl, bub;
            logic [47:0] expv, mask;
            int          maxc;
            dec  = spec_decode(opcode, ej_of(i));
            maxc = (1 << cw_of(i)) - 1;
            haz  = instr_valid && m_ctrl[i][4] && (m_rd[i] != 5'd0) &&
                   ((dec[9] && rs1 == m_rd[i]) || (dec[10] && rs2 == m_rd[i]));
            bub  = 1'b0;
            if (reset)                           {e_pc, e_ifw, e_fl} = 3'b110;
            else if (branch_taken)               {e_pc, e_ifw, e_fl} = 3'b111;
            else if (m_pend[i] > 0 || haz)       {e_pc, e_ifw, e_fl} = 3'b000;
            else                                 {e_pc, e_ifw, e_fl} = 3'b110;

            expv = {16'(m_cnt[i]), 14'd0, e_fl, e_ifw, e_pc, m_ill[i], m_rd[i], m_jump[i], m_ctrl[i]};
            mask = {48{1'b1}};
            if (!m_ok) mask = 48'h0000_0003_8000;
            else if (!m_rdchk[i]) mask[13:9] = 5'd0;
            tests++;
            if ((obs[i] & mask) !== (expv & mask)) begin
                fails++;
                $display("FAIL model_cmp inst=%0d cyc=%0d actual=%h required=%h mask=%h",
                         i, cyc, obs[i], expv, mask);
            end

            n_pend[i] = m_pend[i];
            n_cnt[i]  = m_cnt[i];
            if (reset) begin
                n_pend[i] = 0;
                n_cnt[i]  = 0;
                bub = 1'b1;
            end else if (branch_taken) begin
                n_pend[i] = 0;
                bub = 1'b1;
            end else if (m_pend[i] > 0) begin
                n_pend[i] = m_pend[i] - 1;
                bub = 1'b1;
            end else if (haz) begin
                n_pend[i] = lus_of(i) - 1;
                bub = 1'b1;
            end
            if (bub && !reset && m_cnt[i] < maxc) n_cnt[i] = m_cnt[i] + 1;
            if (bub) begin
                n_ctrl[i] = 8'h00; n_jump[i] = 1'b0; n_rd[i] = 5'd0; n_rdchk[i] = 1'b1; n_ill[i] = 1'b0;
            end else if (instr_valid && dec[11]) begin
                n_ctrl[i] = dec[7:0]; n_jump[i] = dec[8]; n_rd[i] = rd; n_rdchk[i] = 1'b1; n_ill[i] = 1'b0;
            end else begin
                n_ctrl[i] = 8'h00; n_jump[i] = 1'b0; n_rd[i] = 5'd0; n_rdchk[i] = 1'b0; n_ill[i] = instr_valid;
            end
        end
    end

    // Model state advances on the same edge as the DUT
    initial forever begin
        @(posedge clk);
        if (reset) m_ok = 1'b1;
        for (int i = 0; i < NI; i++) begin
            m_ctrl[i] = n_ctrl[i]; m_jump[i] = n_jump[i]; m_rd[i] = n_rd[i];
            m_rdchk[i] = n_rdchk[i]; m_ill[i] = n_ill[i];
            m_cnt[i] = n_cnt[i]; m_pend[i] = n_pend[i];
        end
    end

    // ---------------- directed helpers ----------------
    task automatic chk(input string name, input int inst, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s inst=%0d actual=%0d required=%0d", name, inst, act, exp);
        end
    endtask

    function automatic int f_ctrl(input int i); return int'(obs[i][7:0]);   endfunction
    function automatic int f_jump(input int i); return int'(obs[i][8]);     endfunction
    function automatic int f_rd  (input int i); return int'(obs[i][13:9]);  endfunction
    function automatic int f_ill (input int i); return int'(obs[i][14]);    endfunction
    function automatic int f_pc  (input int i); return int'(obs[i][15]);    endfunction
    function automatic int f_ifw (input int i); return int'(obs[i][16]);    endfunction
    function automatic int f_fl  (input int i); return int'(obs[i][17]);    endfunction
    function automatic int f_cnt (input int i); return int'(obs[i][47:32]); endfunction

    task automatic set_in(input logic v, input logic [6:0] op, input logic [4:0] a,
                          input logic [4:0] b, input logic [4:0] d, input logic br);
        instr_valid = v; opcode = op; rs1 = a; rs2 = b; rd = d; branch_taken = br;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [6:0] ops [12];

    initial begin
        reset = 1'b1;
        set_in(1'b1, OP_LW, 5'd1, 5'd0, 5'd5, 1'b1);
        #1;
        chk("reset_pc_write", 0, f_pc(0), 1);
        chk("reset_if_id_write", 1, f_ifw(1), 1);
        chk("reset_no_flush", 2, f_fl(2), 0);
        tick(); tick();
        for (int i = 0; i < NI; i++) begin
            chk("reset_ex_regs", i, int'(obs[i][14:0]), 0);
            chk("reset_cnt", i, f_cnt(i), 0);
        end

        // lw rd=5 decodes straight into EX
        reset = 1'b0;
        set_in(1'b1, OP_LW, 5'd1, 5'd0, 5'd5, 1'b0);
        tick();
        for (int i = 0; i < NI; i++) begin
            chk("lw_ctrl", i, f_ctrl(i), 8'hF0);
            chk("lw_rd", i, f_rd(i), 5);
            chk("lw_cnt", i, f_cnt(i), 0);
        end
        chk("model_lw_ctrl", 0, int'(m_ctrl[0]), 8'hF0);

        // dependent add: one bubble for variant 0, three for variant 1
        set_in(1'b1, OP_R, 5'd2, 5'd5, 5'd7, 1'b0);
        #1;
        for (int i = 0; i < NI; i++) chk("hazard_pc_low", i, f_pc(i) + f_ifw(i), 0);
        tick();
        for (int i = 0; i < NI; i++) begin
            chk("bubble_ctrl", i, f_ctrl(i) + f_rd(i), 0);
            chk("bubble_cnt1", i, f_cnt(i), 1);
        end
        chk("model_cnt1", 0, m_cnt[0], 1);
        #1;
        chk("single_stall_release", 0, f_pc(0), 1);
        chk("multi_stall_hold", 1, f_pc(1), 0);
        tick();
        chk("add_ctrl", 0, f_ctrl(0), 8'h22);
        chk("add_rd", 0, f_rd(0), 7);
        chk("add_cnt", 0, f_cnt(0), 1);
        chk("stall2_cnt", 1, f_cnt(1), 2);

        set_in(1'b0, OP_NOP, 5'd0, 5'd0, 5'd0, 1'b0);
        tick(); tick(); tick();
        reset = 1'b1; tick(); reset = 1'b0;

        // three-stall variant: branch taken on the second stall cycle
        set_in(1'b1, OP_LW, 5'd1, 5'd0, 5'd5, 1'b0);
        tick();
        set_in(1'b1, OP_R, 5'd2, 5'd5, 5'd7, 1'b0);
        #1; chk("stall_a_pc", 1, f_pc(1), 0);
        tick();
        set_in(1'b1, OP_R, 5'd2, 5'd5, 5'd7, 1'b1);
        #1;
        chk("abort_flush", 1, f_fl(1), 1);
        chk("abort_pc", 1, f_pc(1) + f_ifw(1), 2);
        tick();
        chk("abort_ctrl", 1, f_ctrl(1), 0);
        chk("abort_cnt", 1, f_cnt(1), 2);
        set_in(1'b1, OP_R, 5'd2, 5'd5, 5'd7, 1'b0);
        #1; chk("abort_run_pc", 1, f_pc(1), 1);
        tick();
        chk("abort_add_ctrl", 1, f_ctrl(1), 8'h22);

        // hazard and taken branch in the same cycle
        set_in(1'b1, OP_LW, 5'd1, 5'd0, 5'd5, 1'b0);
        tick();
        set_in(1'b1, OP_R, 5'd2, 5'd5, 5'd7, 1'b1);
        #1;
        for (int i = 0; i < NI; i++) chk("haz_br_flush_pc", i, f_fl(i) + f_pc(i), 2);
        tick();
        for (int i = 0; i < 2; i++) chk("haz_br_cnt", i, f_cnt(i), 3);
        set_in(1'b1, OP_R, 5'd2, 5'd5, 5'd7, 1'b0);
        #1;
        for (int i = 0; i < NI; i++) chk("haz_br_run", i, f_pc(i), 1);
        tick();

        // jal: illegal without jump support, decoded with it
        set_in(1'b1, OP_JAL, 5'd0, 5'd0, 5'd3, 1'b0);
        tick();
        chk("jal_off_ctrl", 0, f_ctrl(0) + f_jump(0), 0);
        chk("jal_off_ill", 0, f_ill(0), 1);
        chk("jal_on_ctrl", 1, f_ctrl(1), 8'h20);
        chk("jal_on_jump", 1, f_jump(1), 1);
        chk("jal_on_rd", 1, f_rd(1), 3);
        chk("jal_on_ill", 1, f_ill(1), 0);
        set_in(1'b0, OP_NOP, 5'd0, 5'd0, 5'd0, 1'b0);
        tick();
        chk("ill_pulse_end", 0, f_ill(0), 0);

        // back-to-back dependent loads: five hazards, then reset mid-stall
        reset = 1'b1; tick(); reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            set_in(1'b1, OP_LW, 5'd5, 5'd0, 5'd5, 1'b0);
            tick();
        end
        chk("sat_cnt", 2, f_cnt(2), 3);
        chk("unsat_cnt", 0, f_cnt(0), 5);
        chk("model_sat_cnt", 2, m_cnt[2], 3);
        #1; chk("in_stall_pc", 1, f_pc(1), 0);
        reset = 1'b1;
        #1; chk("reset_in_stall_pc", 1, f_pc(1), 1);
        tick();
        chk("reset_in_stall_regs", 1, int'(obs[1][14:0]), 0);
        chk("reset_in_stall_cnt", 1, f_cnt(1), 0);
        reset = 1'b0;
        #1; chk("after_reset_run", 1, f_pc(1), 1);
        tick();

        // randomized traffic against the model
        ops = '{OP_NOP, OP_LW, OP_LW, OP_LW, OP_SW, OP_R, OP_I, OP_BR,
                OP_JAL, OP_JALR, OP_LUI, 7'b1111111};
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 99) < 2);
            instr_valid = ($urandom_range(0, 9) != 0);
            opcode = ($urandom_range(0, 19) == 0) ? 7'($urandom) : ops[$urandom_range(0, 11)];
            rs1 = 5'($urandom_range(0, 3));
            rs2 = 5'($urandom_range(0, 3));
            rd  = 5'($urandom_range(0, 3));
            branch_taken = ($urandom_range(0, 15) == 0);
            tick();
        end

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/control_pipe_unit.md
CONTROL_PIPE_UNIT -- requirements
Module: control_pipe_unit

Interface
REQ-001 Parameter REG_AW, default 5, register-index width.
REQ-002 Parameter LOAD_USE_STALLS, default 1, range 1..3, bubbles inserted per load-use hazard.
REQ-003 Parameter ENABLE_JUMP, default 0; 1 adds jal/jalr/lui decode.
REQ-004 Parameter CNT_W, default 16, bubble-counter width.
REQ-005 clk  input  1  rising-edge clock; reset  input  1  synchronous, active-high.
REQ-006 instr_valid  input  1  IF/ID holds a real instruction.
REQ-007 opcode  input  7  instruction[6:0]; rs1, rs2, rd  input  REG_AW  IF/ID register fields.
REQ-008 branch_taken  input  1  EX-stage branch resolved taken.
REQ-009 ex_ALUSrc, ex_MemtoReg, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_Branch, ex_Jump  output  1 each  registered ID/EX controls.
REQ-010 ex_ALUop  output  2; ex_rd  output  REG_AW; both registered ID/EX fields.
REQ-011 pc_write, if_id_write  output  1  combinational; 0 freezes PC and IF/ID.
REQ-012 if_id_flush  output  1  combinational; 1 clears IF/ID.
REQ-013 illegal_op  output  1  registered one-cycle pulse; bubble_cnt  output  CNT_W  registered count.

Function
REQ-014 Decode {ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,Branch,ALUop}, Jump=0: 0000000 -> 00000000; 0000011 -> 11110000; 0100011 -> 10001000; 0110011 -> 00100010; 0010011 -> 10100011; 1100011 -> 00000101.
REQ-015 ENABLE_JUMP=1 adds: 1101111 (jal) -> 00100000, Jump=1; 1100111 (jalr) -> 10100000, Jump=1; 0110111 (lui) -> 10100000, Jump=0.
REQ-016 Any other opcode with instr_valid=1 -> all controls 0 and illegal_op=1 next cycle; instr_valid=0 -> all controls 0, no illegal_op.
REQ-017 "Bubble" = ID/EX loaded with all controls 0 and ex_rd=0 at next edge.
REQ-018 Latency: decoded controls and rd appear on ex_* one cycle after presentation when no stall/flush.
REQ-019 rs2 counts as used only for opcodes 0110011, 0100011, 1100011; rs1 used for all decoded opcodes except 0000000, 1101111, 0110111.
REQ-020 Hazard = instr_valid & ex_MemRead & ex_rd!=0 & ((rs1 used & rs1==ex_rd) | (rs2 used & rs2==ex_rd)).
REQ-021 FSM states RUN, STALL; internal counter stall_left, width 2.
REQ-022 RUN, no hazard, no branch_taken: pc_write=1, if_id_write=1, if_id_flush=0, decode loaded.
REQ-023 RUN, hazard, no branch_taken: bubble, pc_write=0, if_id_write=0; if LOAD_USE_STALLS=1 stay RUN, else go STALL with stall_left=LOAD_USE_STALLS-1.
REQ-024 STALL: bubble, pc_write=0, if_id_write=0, stall_left decrements; at stall_left=1 return to RUN.
REQ-025 branch_taken in any state has priority: bubble, if_id_flush=1, pc_write=1, if_id_write=1, next state RUN, stall aborted, no illegal_op.
REQ-026 bubble_cnt increments by 1 per bubble from REQ-023/024/025, saturates at all-ones.
REQ-027 Hazard re-check after stall: the REQ-020 check uses current ex_* (now zero), so the held instruction decodes normally on exit.

Reset
REQ-028 reset=1 at an edge: state RUN, stall_left=0, all ex_* =0, illegal_op=0, bubble_cnt=0; overrides stall, flush and decode in progress.
REQ-029 While reset=1: pc_write=1, if_id_write=1, if_id_flush=0.

Verification
REQ-030 Reset then lw (0000011, rd=5) -> next cycle ex_* pattern 11110000, ex_rd=5, bubble_cnt=0.
REQ-031 lw rd=5 followed by add (0110011, rs2=5) -> one bubble, pc_write=0 one cycle, add reaches EX two cycles after lw, bubble_cnt=1.
REQ-032 LOAD_USE_STALLS=3, same sequence -> three bubbles, pc_write low three cycles; branch_taken on second stall cycle -> flush, RUN, bubble_cnt=2.
REQ-033 Hazard and branch_taken same cycle -> if_id_flush=1, pc_write=1, one bubble, state RUN.
REQ-034 opcode 1101111 with ENABLE_JUMP=0 -> controls 0, illegal_op pulse one cycle; ENABLE_JUMP=1 -> ex_RegWrite=1, ex_Jump=1, no pulse.
REQ-035 CNT_W=2, five consecutive hazards -> bubble_cnt saturates at 3; reset mid-STALL -> all outputs to REQ-028 values next edge.
